// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   - exception codes carried into IF/ID
//   - fetch FSM state encoding
//   - default address map constants
//   - IF/ID payload struct and the fetch address-legality helper
package if_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [XLEN-1:0] DEF_INIT_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_IM_LO   = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_IM_HI   = 32'h0000_6FFF;
  localparam logic [XLEN-1:0] DEF_EXC_PC  = 32'h0000_4180;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HELD  = 2'd2,
    S_DRAIN = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [EXC_W-1:0] exc_code;
    logic             bd;
  } ifid_t;

  // Misaligned or outside [lo, hi] (unsigned) is an address error on fetch.
  function automatic logic fetch_adel(input logic [XLEN-1:0] pc,
                                      input logic [XLEN-1:0] lo,
                                      input logic [XLEN-1:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush.
// Ports:
//   clk, reset (sync, active-low)
//   load      - capture din, mark valid
//   flush     - overrides load; PC <= flush_pc, rest cleared, valid 0
//   flush_pc  - PC value written on flush
//   din       - payload captured on load
//   d_pc, d_instr, d_exc_code, d_bd, d_valid - registered contents
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RST_PC = DEF_INIT_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [XLEN-1:0]   flush_pc,
  input  ifid_t             din,
  output logic [XLEN-1:0]   d_pc,
  output logic [XLEN-1:0]   d_instr,
  output logic [EXC_W-1:0]  d_exc_code,
  output logic              d_bd,
  output logic              d_valid
);

  // Flush beats load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_pc       <= RST_PC;
      d_instr    <= '0;
      d_exc_code <= EXC_INT;
      d_bd       <= 1'b0;
      d_valid    <= 1'b0;
    end else if (flush) begin
      d_pc       <= flush_pc;
      d_instr    <= '0;
      d_exc_code <= EXC_INT;
      d_bd       <= 1'b0;
      d_valid    <= 1'b0;
    end else if (load) begin
      d_pc       <= din.pc;
      d_instr    <= din.instr;
      d_exc_code <= din.exc_code;
      d_bd       <= din.bd;
      d_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory, flags AdEL on illegal fetch addresses and feeds IF/ID.
// Ports:
//   clk, reset (sync, active-low)
//   nPC, block, Req, is_branch_D         - from PC_Calc / hazard unit / CP0 / ID
//   PC                                   - current fetch PC back to PC_Calc
//   im_req, im_addr, im_ready, im_rdata  - instruction memory handshake
//   fetch_busy                           - fetch not complete this cycle
//   D_PC, D_Instr, D_ExcCode, D_BD, D_valid - IF/ID contents
// Optional (macro IF_PERF_CNT_EN): perf_fetch_cnt, perf_wait_cnt.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] INIT_PC = DEF_INIT_PC,
  parameter logic [XLEN-1:0] IM_LO   = DEF_IM_LO,
  parameter logic [XLEN-1:0] IM_HI   = DEF_IM_HI,
  parameter logic [XLEN-1:0] EXC_PC  = DEF_EXC_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   nPC,
  input  logic              block,
  input  logic              Req,
  input  logic              is_branch_D,
  output logic [XLEN-1:0]   PC,
  output logic              im_req,
  output logic [XLEN-1:0]   im_addr,
  input  logic              im_ready,
  input  logic [XLEN-1:0]   im_rdata,
  output logic              fetch_busy,
  output logic [XLEN-1:0]   D_PC,
  output logic [XLEN-1:0]   D_Instr,
  output logic [EXC_W-1:0]  D_ExcCode,
  output logic              D_BD,
`ifdef IF_PERF_CNT_EN
  output logic [XLEN-1:0]   perf_fetch_cnt,
  output logic [XLEN-1:0]   perf_wait_cnt,
`endif
  output logic              D_valid
);

  if_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  hold_instr_q;
  logic [EXC_W-1:0] hold_exc_q;

  logic             adel;
  logic             done;
  logic             req_raw;
  logic             ifid_ld;
  logic             ifid_fl;
  logic             hold_ld;
  logic [XLEN-1:0]  fetch_data;
  logic [EXC_W-1:0] fetch_exc;
  ifid_t            ifid_din;

  assign adel    = fetch_adel(pc_q, IM_LO, IM_HI);
  assign PC      = pc_q;
  assign im_addr = {pc_q[XLEN-1:2], 2'b00};
  // No request may be seen by memory while reset is asserted.
  assign im_req  = req_raw & reset;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // PC and hold buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= INIT_PC;
      hold_instr_q <= '0;
      hold_exc_q   <= EXC_INT;
    end else begin
      pc_q <= pc_d;
      if (hold_ld) begin
        hold_instr_q <= fetch_data;
        hold_exc_q   <= fetch_exc;
      end
    end
  end

  // Next-state, fetch result mux and IF/ID / PC control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_raw    = 1'b0;
    fetch_busy = 1'b0;
    done       = 1'b0;
    fetch_data = '0;
    fetch_exc  = EXC_INT;
    ifid_ld    = 1'b0;
    ifid_fl    = 1'b0;
    hold_ld    = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_raw    = !adel;
        done       = adel | im_ready;
        fetch_busy = !done;
        fetch_data = adel ? '0 : im_rdata;
        fetch_exc  = adel ? EXC_ADEL : EXC_INT;
      end
      S_WAIT: begin
        req_raw    = 1'b1;
        fetch_busy = 1'b1;
        done       = im_ready;
        fetch_data = im_rdata;
      end
      S_HELD: begin
        done       = 1'b1;
        fetch_data = hold_instr_q;
        fetch_exc  = hold_exc_q;
      end
      S_DRAIN: begin
        req_raw    = 1'b1;
        fetch_busy = 1'b1;
      end
      default: ;
    endcase

    if (Req) begin
      ifid_fl = 1'b1;
      // An in-flight request must be drained before refetching from EXC_PC.
      if (((state_q == S_WAIT) || (state_q == S_DRAIN) ||
           ((state_q == S_FETCH) && !adel)) && !im_ready) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
        pc_d    = EXC_PC;
      end
    end else begin
      case (state_q)
        S_FETCH, S_WAIT, S_HELD: begin
          if (done && !block) begin
            ifid_ld = 1'b1;
            pc_d    = nPC;
            state_d = S_FETCH;
          end else if (done && block) begin
            hold_ld = (state_q != S_HELD);
            state_d = S_HELD;
          end else if (state_q == S_FETCH) begin
            state_d = S_WAIT;
          end
        end
        S_DRAIN: begin
          if (im_ready) begin
            state_d = S_FETCH;
            pc_d    = EXC_PC;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign ifid_din = '{pc: pc_q, instr: fetch_data, exc_code: fetch_exc,
                      bd: is_branch_D};

  if_id_reg #(
    .RST_PC (INIT_PC)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_ld),
    .flush      (ifid_fl),
    .flush_pc   (EXC_PC),
    .din        (ifid_din),
    .d_pc       (D_PC),
    .d_instr    (D_Instr),
    .d_exc_code (D_ExcCode),
    .d_bd       (D_BD),
    .d_valid    (D_valid)
  );

`ifdef IF_PERF_CNT_EN
  // Fetch/wait event counters; free-running, wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (ifid_ld && !ifid_fl) perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
      if (fetch_busy)          perf_wait_cnt  <= perf_wait_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] nPC;
  logic        block;
  logic        Req;
  logic        is_branch_D;
  logic [31:0] PC;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        fetch_busy;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;
  logic        D_valid;

  int n_chk  = 0;
  int n_fail = 0;

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .nPC         (nPC),
    .block       (block),
    .Req         (Req),
    .is_branch_D (is_branch_D),
    .PC          (PC),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ready    (im_ready),
    .im_rdata    (im_rdata),
    .fetch_busy  (fetch_busy),
    .D_PC        (D_PC),
    .D_Instr     (D_Instr),
    .D_ExcCode   (D_ExcCode),
    .D_BD        (D_BD),
    .D_valid     (D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] npc;
    logic        blk;
    logic        rq;
    logic        br;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_busy;
    logic [31:0] e_dpc;
    logic [31:0] e_dins;
    logic [4:0]  e_dexc;
    logic        e_dbd;
    logic        e_dv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic [31:0] npc,
                              input logic blk, input logic rq, input logic br,
                              input logic rdy, input logic [31:0] rdata,
                              input logic [31:0] e_pc, input logic e_req,
                              input logic e_busy, input logic [31:0] e_dpc,
                              input logic [31:0] e_dins, input logic [4:0] e_dexc,
                              input logic e_dbd, input logic e_dv);
    vec_t v;
    v.rst = rst; v.npc = npc; v.blk = blk; v.rq = rq; v.br = br;
    v.rdy = rdy; v.rdata = rdata; v.e_pc = e_pc; v.e_req = e_req;
    v.e_busy = e_busy; v.e_dpc = e_dpc; v.e_dins = e_dins;
    v.e_dexc = e_dexc; v.e_dbd = e_dbd; v.e_dv = e_dv;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_pre(input int row, input logic [31:0] e_pc,
                         input logic e_req, input logic e_busy);
    logic [31:0] e_addr;
    e_addr = {e_pc[31:2], 2'b00};
    chk("PC", row, PC, e_pc);
    chk("im_addr", row, im_addr, e_addr);
    chk("im_req", row, 32'(im_req), 32'(e_req));
    chk("fetch_busy", row, 32'(fetch_busy), 32'(e_busy));
  endtask

  task automatic chk_post(input int row, input logic [31:0] dpc,
                          input logic [31:0] dins, input logic [4:0] dexc,
                          input logic dbd, input logic dv);
    chk("D_PC", row, D_PC, dpc);
    chk("D_Instr", row, D_Instr, dins);
    chk("D_ExcCode", row, 32'(D_ExcCode), 32'(dexc));
    chk("D_BD", row, 32'(D_BD), 32'(dbd));
    chk("D_valid", row, 32'(D_valid), 32'(dv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Zero-wait stream with a branch marking the load of 3008
    vq.push_back(mk(1, 32'h3004, 0, 0, 0, 1, 32'hA000_3000, 32'h3000, 1, 0, 32'h3000, 32'hA000_3000, 0, 0, 1));
    vq.push_back(mk(1, 32'h3008, 0, 0, 0, 1, 32'hA000_3004, 32'h3004, 1, 0, 32'h3004, 32'hA000_3004, 0, 0, 1));
    vq.push_back(mk(1, 32'h300C, 0, 0, 1, 1, 32'hA000_3008, 32'h3008, 1, 0, 32'h3008, 32'hA000_3008, 0, 1, 1));
    // Two wait cycles, data on the third
    vq.push_back(mk(1, 32'h3010, 0, 0, 0, 0, 32'h0,         32'h300C, 1, 1, 32'h3008, 32'hA000_3008, 0, 1, 1));
    vq.push_back(mk(1, 32'h3010, 0, 0, 0, 0, 32'h0,         32'h300C, 1, 1, 32'h3008, 32'hA000_3008, 0, 1, 1));
    vq.push_back(mk(1, 32'h3010, 0, 0, 0, 1, 32'hA000_300C, 32'h300C, 1, 1, 32'h300C, 32'hA000_300C, 0, 0, 1));
    // Data returns in S_WAIT while blocked -> held, released later
    vq.push_back(mk(1, 32'h3014, 0, 0, 0, 0, 32'h0,         32'h3010, 1, 1, 32'h300C, 32'hA000_300C, 0, 0, 1));
    vq.push_back(mk(1, 32'h3014, 1, 0, 0, 1, 32'h1234_5678, 32'h3010, 1, 1, 32'h300C, 32'hA000_300C, 0, 0, 1));
    vq.push_back(mk(1, 32'h3014, 1, 0, 0, 0, 32'h0,         32'h3010, 0, 0, 32'h300C, 32'hA000_300C, 0, 0, 1));
    vq.push_back(mk(1, 32'h3014, 0, 0, 0, 0, 32'h0,         32'h3010, 0, 0, 32'h3010, 32'h1234_5678, 0, 0, 1));
    // Blocked zero-wait fetch; im_ready in S_HELD is ignored
    vq.push_back(mk(1, 32'h3018, 1, 0, 0, 1, 32'hA000_3014, 32'h3014, 1, 0, 32'h3010, 32'h1234_5678, 0, 0, 1));
    vq.push_back(mk(1, 32'h3018, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h3014, 0, 0, 32'h3014, 32'hA000_3014, 0, 0, 1));
    // AdEL: misaligned, above IM_HI, below IM_LO, then top legal word
    vq.push_back(mk(1, 32'h3002, 0, 0, 0, 1, 32'hA000_3018, 32'h3018, 1, 0, 32'h3018, 32'hA000_3018, 0, 0, 1));
    vq.push_back(mk(1, 32'h7000, 0, 0, 0, 1, 32'h5555_5555, 32'h3002, 0, 0, 32'h3002, 32'h0,         4, 0, 1));
    vq.push_back(mk(1, 32'h2FFC, 0, 0, 0, 0, 32'h0,         32'h7000, 0, 0, 32'h7000, 32'h0,         4, 0, 1));
    vq.push_back(mk(1, 32'h6FFC, 0, 0, 0, 0, 32'h0,         32'h2FFC, 0, 0, 32'h2FFC, 32'h0,         4, 0, 1));
    vq.push_back(mk(1, 32'h3020, 0, 0, 0, 1, 32'hA000_6FFC, 32'h6FFC, 1, 0, 32'h6FFC, 32'hA000_6FFC, 0, 0, 1));
    // Req during S_WAIT -> drain, then refetch from EXC_PC
    vq.push_back(mk(1, 32'h3024, 0, 0, 0, 0, 32'h0,         32'h3020, 1, 1, 32'h6FFC, 32'hA000_6FFC, 0, 0, 1));
    vq.push_back(mk(1, 32'h3024, 0, 1, 0, 0, 32'h0,         32'h3020, 1, 1, 32'h4180, 32'h0,         0, 0, 0));
    vq.push_back(mk(1, 32'h3024, 0, 0, 0, 0, 32'h0,         32'h3020, 1, 1, 32'h4180, 32'h0,         0, 0, 0));
    vq.push_back(mk(1, 32'h3024, 0, 0, 0, 1, 32'h9999_9999, 32'h3020, 1, 1, 32'h4180, 32'h0,         0, 0, 0));
    vq.push_back(mk(1, 32'h4184, 0, 0, 0, 1, 32'hA000_4180, 32'h4180, 1, 0, 32'h4180, 32'hA000_4180, 0, 0, 1));
    // Req with completed fetch overrides block and nPC
    vq.push_back(mk(1, 32'h9998, 1, 1, 0, 1, 32'hA000_4184, 32'h4184, 1, 0, 32'h4180, 32'h0,         0, 0, 0));
    vq.push_back(mk(1, 32'h4184, 0, 0, 0, 1, 32'hA000_4180, 32'h4180, 1, 0, 32'h4180, 32'hA000_4180, 0, 0, 1));
    // Req in S_HELD drops the hold buffer
    vq.push_back(mk(1, 32'h4188, 1, 0, 0, 1, 32'hA000_4184, 32'h4184, 1, 0, 32'h4180, 32'hA000_4180, 0, 0, 1));
    vq.push_back(mk(1, 32'h4188, 1, 1, 0, 0, 32'h0,         32'h4184, 0, 0, 32'h4180, 32'h0,         0, 0, 0));
    vq.push_back(mk(1, 32'h4184, 0, 0, 0, 1, 32'h1111_1111, 32'h4180, 1, 0, 32'h4180, 32'h1111_1111, 0, 0, 1));
    // Reset while in S_WAIT, then resume from INIT_PC
    vq.push_back(mk(1, 32'h4188, 0, 0, 0, 0, 32'h0,         32'h4184, 1, 1, 32'h4180, 32'h1111_1111, 0, 0, 1));
    vq.push_back(mk(0, 32'h4188, 0, 0, 0, 0, 32'h0,         32'h4184, 0, 1, 32'h3000, 32'h0,         0, 0, 0));
    vq.push_back(mk(1, 32'h3004, 0, 0, 0, 1, 32'hA000_3000, 32'h3000, 1, 0, 32'h3000, 32'hA000_3000, 0, 0, 1));

    reset = 1'b0; nPC = '0; block = 1'b0; Req = 1'b0; is_branch_D = 1'b0;
    im_ready = 1'b0; im_rdata = '0;

    // Reset state, with reset still asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_pre(-1, 32'h3000, 1'b0, 1'b1);
    chk_post(-1, 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset       = vq[i].rst;
      nPC         = vq[i].npc;
      block       = vq[i].blk;
      Req         = vq[i].rq;
      is_branch_D = vq[i].br;
      im_ready    = vq[i].rdy;
      im_rdata    = vq[i].rdata;
      #1;
      chk_pre(i, vq[i].e_pc, vq[i].e_req, vq[i].e_busy);
      @(posedge clk);
      #1;
      chk_post(i, vq[i].e_dpc, vq[i].e_dins, vq[i].e_dexc, vq[i].e_dbd, vq[i].e_dv);
    end

    // Hand sequence: Req while S_DRAIN persists, drain ends on im_ready
    @(negedge clk);
    nPC = 32'h3008; block = 1'b0; Req = 1'b0; im_ready = 1'b0;
    #1;
    chk("seq_wait_busy", 100, 32'(fetch_busy), 32'h1);
    @(negedge clk);
    Req = 1'b1;
    @(negedge clk);
    Req = 1'b1;
    #1;
    chk("seq_drain_req", 101, 32'(im_req), 32'h1);
    chk("seq_drain_pc", 101, PC, 32'h3004);
    @(negedge clk);
    Req = 1'b0; im_ready = 1'b1; im_rdata = 32'h7777_7777;
    @(posedge clk);
    #1;
    chk("seq_drain_exit_pc", 102, PC, 32'h4180);
    chk("seq_drain_dvalid", 102, 32'(D_valid), 32'h0);
    chk("seq_drain_exit_busy", 102, 32'(fetch_busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
